// File: rtl/pipe_ce_ctrl.sv
// pipe_ce_ctrl: clock-enable/valid sequencer for a DEPTH-stage pipeline with flush and drain; PIPE_CE_CTRL_STATS_EN adds transfer/stall counters
module pipe_ce_ctrl #(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [DEPTH-1:0] ce,
  output logic [DEPTH-1:0] stage_vld,
  output logic [CW-1:0]    occupancy,
  input  logic             flush,
  input  logic             drain_req,
  output logic             drain_done
`ifdef PIPE_CE_CTRL_STATS_EN
  ,
  output logic [31:0]      xfer_cnt,
  output logic [31:0]      stall_cnt
`endif
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [DEPTH-1:0] v_q, v_d, adv, vin;
  logic a;
  always_comb begin
    a = m_ready | ~v_q[DEPTH-1];
    adv = '0;
    adv[DEPTH-1] = a;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      a = a | ~v_q[i];
      adv[i] = a;
    end
  end
  always_comb begin
    occupancy = '0;
    for (int i = 0; i < DEPTH; i++) occupancy = occupancy + CW'(v_q[i]);
  end
  assign s_ready    = adv[0] & (state_q == RUN) & ~flush;
  assign vin        = {v_q[DEPTH-2:0], s_valid & s_ready};
  assign ce         = adv & vin & {DEPTH{~flush}};
  assign v_d        = flush ? '0 : (adv & vin) | (~adv & v_q);
  assign m_valid    = v_q[DEPTH-1];
  assign stage_vld  = v_q;
  assign drain_done = (state_q == DONE);
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  state_d = RUN;
      RUN:   state_d = drain_req ? DRAIN : RUN;
      DRAIN: state_d = (occupancy == '0) ? DONE : DRAIN;
      DONE:  state_d = RUN;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      v_q     <= '0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
    end
  end
`ifdef PIPE_CE_CTRL_STATS_EN
  logic [31:0] xfer_q, xfer_d, stall_q, stall_d;
  assign xfer_d    = (m_valid & m_ready & ~&xfer_q) ? xfer_q + 32'd1 : xfer_q;
  assign stall_d   = (m_valid & ~m_ready & ~&stall_q) ? stall_q + 32'd1 : stall_q;
  assign xfer_cnt  = xfer_q;
  assign stall_cnt = stall_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_q  <= '0;
      stall_q <= '0;
    end else begin
      xfer_q  <= xfer_d;
      stall_q <= stall_d;
    end
  end
`endif
endmodule

// File: tb/tb_pipe_ce_ctrl.sv
// tb_pipe_ce_ctrl: directed checks of pipe_ce_ctrl (DEPTH=4) using a ce-driven data shadow pipeline
module tb_pipe_ce_ctrl;
  logic clk = 0, rst_n = 0, s_valid = 0, m_ready = 0, flush = 0, drain_req = 0;
  logic s_ready, m_valid, drain_done;
  logic [3:0] ce, stage_vld;
  logic [2:0] occupancy;
`ifdef PIPE_CE_CTRL_STATS_EN
  logic [31:0] xfer_cnt, stall_cnt;
`endif
  int checks = 0, failures = 0, next_id = 0;
  logic [7:0] din = 0;
  logic [7:0] data [4];

  pipe_ce_ctrl #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
    .m_valid(m_valid), .m_ready(m_ready), .ce(ce), .stage_vld(stage_vld),
    .occupancy(occupancy), .flush(flush), .drain_req(drain_req), .drain_done(drain_done)
`ifdef PIPE_CE_CTRL_STATS_EN
    , .xfer_cnt(xfer_cnt), .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ce[0]) data[0] <= din;
    for (int i = 1; i < 4; i++) if (ce[i]) data[i] <= data[i-1];
  end

  task tick;
    @(posedge clk);
    #2;
  endtask

  task start;
    rst_n = 0; s_valid = 0; m_ready = 0; flush = 0; drain_req = 0;
    tick;
    rst_n = 1;
    tick;
  endtask

  task fill(input int n);
    for (int k = 0; k < n; k++) begin
      s_valid = 1;
      din = 8'(next_id);
      #1;
      if (s_ready) next_id++;
      tick;
    end
    s_valid = 0;
  endtask

  task test_reset;
    start;
    m_ready = 0;
    fill(2);
    rst_n = 0;
    #1;
    checks++;
    if ({s_ready, m_valid, ce, stage_vld, occupancy, drain_done} !== 15'd0) begin
      failures++;
      $display("FAIL reset_outputs got s_ready=%b m_valid=%b ce=%b vld=%b occ=%0d done=%b exp all 0",
               s_ready, m_valid, ce, stage_vld, occupancy, drain_done);
    end
`ifdef PIPE_CE_CTRL_STATS_EN
    checks++;
    if (xfer_cnt !== 0 || stall_cnt !== 0) begin
      failures++;
      $display("FAIL reset_stats got xfer=%0d stall=%0d exp 0 0", xfer_cnt, stall_cnt);
    end
`endif
    tick;
    rst_n = 1; s_valid = 1; m_ready = 1; din = 0;
    #1;
    checks++;
    if (s_ready !== 1'b0) begin
      failures++;
      $display("FAIL idle_s_ready got=%b exp=0", s_ready);
    end
  endtask

  task test_back_to_back;
    int sent, rcv, fi, fo, lo;
    sent = 0; rcv = 0; fi = -1; fo = -1; lo = -1;
    for (int c = 0; c < 40; c++) begin
      tick;
      s_valid = (sent < 10);
      din = 8'(sent);
      m_ready = 1;
      #1;
      if (c == 0) begin
        checks++;
        if (s_ready !== 1'b1) begin
          failures++;
          $display("FAIL run_s_ready got=%b exp=1", s_ready);
        end
      end
      if (m_valid) begin
        checks++;
        if (data[3] !== 8'(rcv)) begin
          failures++;
          $display("FAIL b2b_order got=%0d exp=%0d", data[3], rcv);
        end
        if (rcv == 0) fo = c;
        lo = c;
        rcv++;
      end
      if (s_valid && s_ready) begin
        if (sent == 0) fi = c;
        sent++;
      end
    end
    s_valid = 0;
    checks++;
    if (rcv != 10) begin
      failures++;
      $display("FAIL b2b_count got=%0d exp=10", rcv);
    end
    checks++;
    if (fo - fi != 4) begin
      failures++;
      $display("FAIL b2b_latency got=%0d exp=4", fo - fi);
    end
    checks++;
    if (lo - fo != 9) begin
      failures++;
      $display("FAIL b2b_span got=%0d exp=9", lo - fo);
    end
  endtask

  task test_fill_stall;
    logic [7:0] base;
    start;
    m_ready = 0;
    base = 8'(next_id);
    fill(4);
    s_valid = 1;
    din = 8'hEE;
    #1;
    checks++;
    if (occupancy !== 3'd4 || s_ready !== 1'b0 || ce !== 4'b0000 || stage_vld !== 4'b1111) begin
      failures++;
      $display("FAIL full_stall got occ=%0d s_ready=%b ce=%b vld=%b exp 4 0 0000 1111",
               occupancy, s_ready, ce, stage_vld);
    end
    tick;
    #1;
    checks++;
    if (data[3] !== base || data[0] !== base + 8'd3) begin
      failures++;
      $display("FAIL full_hold got out=%0d in=%0d exp %0d %0d", data[3], data[0], base, base + 8'd3);
    end
    m_ready = 1;
    #1;
    checks++;
    if (ce !== 4'b1111 || s_ready !== 1'b1) begin
      failures++;
      $display("FAIL full_release got ce=%b s_ready=%b exp 1111 1", ce, s_ready);
    end
    tick;
    s_valid = 0;
    #1;
    checks++;
    if (occupancy !== 3'd4 || data[3] !== base + 8'd1 || data[0] !== 8'hEE) begin
      failures++;
      $display("FAIL full_swap got occ=%0d out=%0d in=%0d exp 4 %0d 238",
               occupancy, data[3], data[0], base + 8'd1);
    end
  endtask

  task test_bubble;
    start;
    m_ready = 0;
    s_valid = 1; din = 8'h40;
    tick;
    s_valid = 0;
    tick;
    s_valid = 1; din = 8'h41;
    tick;
    s_valid = 0;
    tick;
    tick;
    #1;
    checks++;
    if (stage_vld !== 4'b1100 || occupancy !== 3'd2) begin
      failures++;
      $display("FAIL bubble_pack got vld=%b occ=%0d exp 1100 2", stage_vld, occupancy);
    end
    checks++;
    if (data[3] !== 8'h40 || data[2] !== 8'h41) begin
      failures++;
      $display("FAIL bubble_data got s3=%h s2=%h exp 40 41", data[3], data[2]);
    end
    tick;
    #1;
    checks++;
    if (stage_vld !== 4'b1100 || ce !== 4'b0000) begin
      failures++;
      $display("FAIL bubble_hold got vld=%b ce=%b exp 1100 0000", stage_vld, ce);
    end
  endtask

  task test_drain;
    logic [2:0] exp_occ [6];
    logic exp_dd [6];
    logic exp_sr [6];
    exp_occ = '{3'd3, 3'd2, 3'd1, 3'd0, 3'd0, 3'd0};
    exp_dd  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    exp_sr  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    start;
    m_ready = 0;
    fill(3);
    drain_req = 1; m_ready = 1; s_valid = 0;
    #1;
    checks++;
    if (occupancy !== 3'd3 || s_ready !== 1'b1) begin
      failures++;
      $display("FAIL drain_entry got occ=%0d s_ready=%b exp 3 1", occupancy, s_ready);
    end
    tick;
    drain_req = 0; s_valid = 1; din = 8'h77;
    for (int k = 0; k < 6; k++) begin
      #1;
      checks++;
      if (occupancy !== exp_occ[k] || drain_done !== exp_dd[k] || s_ready !== exp_sr[k]) begin
        failures++;
        $display("FAIL drain_seq%0d got occ=%0d done=%b s_ready=%b exp %0d %b %b",
                 k, occupancy, drain_done, s_ready, exp_occ[k], exp_dd[k], exp_sr[k]);
      end
      tick;
    end
    s_valid = 0;
  endtask

  task test_flush;
    start;
    m_ready = 0;
    fill(4);
    flush = 1; s_valid = 1;
    #1;
    checks++;
    if (s_ready !== 1'b0 || ce !== 4'b0000 || occupancy !== 3'd4) begin
      failures++;
      $display("FAIL flush_cycle got s_ready=%b ce=%b occ=%0d exp 0 0000 4", s_ready, ce, occupancy);
    end
    tick;
    flush = 0; s_valid = 0;
    #1;
    checks++;
    if (stage_vld !== 4'b0000 || m_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_clear got vld=%b m_valid=%b exp 0000 0", stage_vld, m_valid);
    end
    drain_req = 1;
    tick;
    drain_req = 0;
    #1;
    checks++;
    if (drain_done !== 1'b0) begin
      failures++;
      $display("FAIL empty_drain_early got=%b exp=0", drain_done);
    end
    tick;
    #1;
    checks++;
    if (drain_done !== 1'b1) begin
      failures++;
      $display("FAIL empty_drain_done got=%b exp=1", drain_done);
    end
    tick;
    #1;
    checks++;
    if (drain_done !== 1'b0 || s_ready !== 1'b1) begin
      failures++;
      $display("FAIL empty_drain_after got done=%b s_ready=%b exp 0 1", drain_done, s_ready);
    end
    fill(2);
    drain_req = 1;
    tick;
    drain_req = 0;
    tick;
    #1;
    checks++;
    if (drain_done !== 1'b0 || occupancy !== 3'd2) begin
      failures++;
      $display("FAIL drain_stuck got done=%b occ=%0d exp 0 2", drain_done, occupancy);
    end
    flush = 1;
    tick;
    flush = 0;
    #1;
    checks++;
    if (drain_done !== 1'b0 || occupancy !== 3'd0) begin
      failures++;
      $display("FAIL drain_flush got done=%b occ=%0d exp 0 0", drain_done, occupancy);
    end
    tick;
    #1;
    checks++;
    if (drain_done !== 1'b1) begin
      failures++;
      $display("FAIL drain_flush_done got=%b exp=1", drain_done);
    end
  endtask

`ifdef PIPE_CE_CTRL_STATS_EN
  task test_stats;
    start;
    m_ready = 0;
    fill(4);
    tick;
    tick;
    tick;
    m_ready = 1; s_valid = 1; din = 8'h55;
    tick;
    s_valid = 0;
    for (int k = 0; k < 4; k++) tick;
    #1;
    checks++;
    if (xfer_cnt !== 32'd5 || stall_cnt !== 32'd3) begin
      failures++;
      $display("FAIL stats_count got xfer=%0d stall=%0d exp 5 3", xfer_cnt, stall_cnt);
    end
    m_ready = 0; flush = 1;
    tick;
    flush = 0;
    tick;
    #1;
    checks++;
    if (xfer_cnt !== 32'd5 || stall_cnt !== 32'd3) begin
      failures++;
      $display("FAIL stats_flush got xfer=%0d stall=%0d exp 5 3", xfer_cnt, stall_cnt);
    end
  endtask
`endif

  initial begin
    test_reset;
    test_back_to_back;
    test_fill_stall;
    test_bubble;
    test_drain;
    test_flush;
`ifdef PIPE_CE_CTRL_STATS_EN
    test_stats;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
